// File: rtl/hex_display_ctrl.sv
// Purpose : multi-digit active-low seven-segment controller; hex or decimal (double-dabble) display.
// Latency : hex LOAD -> HEX after 2 edges; decimal LOAD -> BUSY for WIDTH+1 cycles, HEX one edge after commit.
// Backpr. : LOAD is dropped while BUSY=1 (including the commit cycle); no queueing of requests.
//
// Ports:
//   CLOCK_50 / RESET      clock, asynchronous active-high reset
//   LOAD, DATA, MODE,     capture strobe, binary value, 0=hex 1=decimal,
//   BLANK_LZ              leading-zero blanking (captured together with DATA)
//   BLINK_EN              live blink enable
//   BUSY, OVF             conversion in progress, decimal value too large for DIGITS
//   HEX                   segments, digit k on HEX[7k+6:7k], bit0=a..bit6=g, active-low
module hex_display_ctrl #(
  parameter int DIGITS    = 6,
  parameter int WIDTH     = 24,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  LOAD,
  input  logic [WIDTH-1:0]      DATA,
  input  logic                  MODE,
  input  logic                  BLANK_LZ,
  input  logic                  BLINK_EN,
  output logic                  BUSY,
  output logic                  OVF,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state;
  logic [WIDTH-1:0]    digits;       // value currently rendered, one nibble per digit
  logic [WIDTH-1:0]    bcd;
  logic [WIDTH-1:0]    bcd_adj;
  logic [WIDTH-1:0]    shreg;
  logic [CW-1:0]       shift_cnt;
  logic                ovf_int;
  logic                blank_lz_lat; // blanking mode that goes with the rendered digits
  logic                blank_lz_pend;// blanking mode waiting for the conversion to commit
  logic [BW-1:0]       blink_cnt;
  logic                blink_on;
  logic [7*DIGITS-1:0] hex_nxt;
  logic [3:0]          nib;
  logic                leading;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any BCD digit >= 5 would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      BUSY          <= 1'b0;
      OVF           <= 1'b0;
      digits        <= '0;
      bcd           <= '0;
      shreg         <= '0;
      shift_cnt     <= '0;
      ovf_int       <= 1'b0;
      blank_lz_lat  <= 1'b0;
      blank_lz_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LOAD) begin
            if (!MODE) begin
              digits       <= DATA;
              OVF          <= 1'b0;
              blank_lz_lat <= BLANK_LZ;
            end else begin
              bcd           <= '0;
              shreg         <= DATA;
              shift_cnt     <= '0;
              ovf_int       <= 1'b0;
              blank_lz_pend <= BLANK_LZ;
              BUSY          <= 1'b1;
              state         <= SHIFT;
            end
          end
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adj[WIDTH-2:0], shreg, 1'b0};
          // A bit leaving the top digit means the value needs more digits than we have.
          if (bcd_adj[WIDTH-1]) begin
            ovf_int <= 1'b1;
          end
          shift_cnt <= shift_cnt + 1'b1;
          if (shift_cnt == CW'(WIDTH-1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          digits       <= bcd;
          OVF          <= ovf_int;
          blank_lz_lat <= blank_lz_pend;
          BUSY         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running blink timebase, independent of load/conversion activity.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV-1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Rendering priority: blink-off > overflow dashes > leading-zero blanking > digit.
  always_comb begin
    hex_nxt = '1;
    leading = 1'b1;
    nib     = 4'd0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      nib = digits[4*k +: 4];
      if (OVF) begin
        hex_nxt[7*k +: 7] = 7'b0111111;
      end else if (blank_lz_lat && leading && (nib == 4'd0) && (k != 0)) begin
        hex_nxt[7*k +: 7] = 7'b1111111;
      end else begin
        hex_nxt[7*k +: 7] = seg7(nib);
        leading           = 1'b0;
      end
    end
    if (BLINK_EN && !blink_on) begin
      hex_nxt = '1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      HEX <= '1;
    end else begin
      HEX <= hex_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int DIGITS = 6;
  localparam int WIDTH  = 24;
  localparam int HW     = 7*DIGITS;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic             CLOCK_50 = 1'b0;
  logic             RESET;
  logic             LOAD;
  logic [WIDTH-1:0] DATA;
  logic             MODE;
  logic             BLANK_LZ;
  logic             BLINK_EN;
  logic             BUSY;
  logic             OVF;
  logic [HW-1:0]    HEX;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [HW-1:0] hex;
    logic          ovf;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             mode;
    logic             blz;
    logic             exp_ovf;
    logic             has_lit;
    logic [HW-1:0]    lit;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  hex_display_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH), .BLINK_DIV(4)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .LOAD(LOAD),
    .DATA(DATA),
    .MODE(MODE),
    .BLANK_LZ(BLANK_LZ),
    .BLINK_EN(BLINK_EN),
    .BUSY(BUSY),
    .OVF(OVF),
    .HEX(HEX)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference display: decimal digits via division, not shift-add-3.
  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic m, input logic b);
    exp_t       r;
    logic [3:0] n [DIGITS];
    int         v;
    int         msd;
    v     = int'(d);
    r.ovf = m && (v > 999999);
    for (int k = 0; k < DIGITS; k++) begin
      if (!m) n[k] = d[4*k +: 4];
      else begin
        n[k] = 4'(v % 10);
        v    = v / 10;
      end
    end
    msd = 0;
    for (int k = 0; k < DIGITS; k++) if (n[k] != 4'd0) msd = k;
    for (int k = 0; k < DIGITS; k++) begin
      if (r.ovf)              r.hex[7*k +: 7] = 7'b0111111;
      else if (b && (k > msd)) r.hex[7*k +: 7] = 7'b1111111;
      else                    r.hex[7*k +: 7] = SEG[n[k]];
    end
    return r;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue required pending entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hex"}, 64'(HEX), 64'(e.hex));
      check({tag, "_ovf"}, 64'(OVF), 64'(e.ovf));
    end
  endtask

  task automatic run_load(input logic [WIDTH-1:0] d, input logic m, input logic b,
                          input logic eovf, input string tag);
    exp_t          e;
    logic [HW-1:0] prev;
    int            n;
    bit            held;
    e     = model(d, m, b);
    e.ovf = eovf;
    sb.push_back(e);
    prev  = HEX;
    DATA = d; MODE = m; BLANK_LZ = b; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    if (!m) begin
      check({tag, "_busy_e"}, 64'(BUSY), 64'd0);
      step();
      check({tag, "_busy_e1"}, 64'(BUSY), 64'd0);
    end else begin
      n    = 0;
      held = 1'b1;
      while (BUSY && n < 100) begin
        if (HEX !== prev) held = 1'b0;
        n++;
        step();
      end
      check({tag, "_busy_cycles"}, 64'(n), 64'(WIDTH+1));
      if (HEX !== prev) held = 1'b0;
      check({tag, "_hold"}, 64'(held), 64'd1);
      step();
    end
    pop_check(tag);
  endtask

  initial begin
    exp_t          e;
    logic [HW-1:0] disp;
    int            s[24];
    int            t0;
    int            bad;

    vecs[0]  = '{24'h00A12F, 1'b0, 1'b0, 1'b0, 1'b1,
                 {7'b1000000, 7'b1000000, 7'b0001000, 7'b1111001, 7'b0100100, 7'b0001110}};
    vecs[1]  = '{24'd123456, 1'b1, 1'b0, 1'b0, 1'b1,
                 {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
    vecs[2]  = '{24'd42, 1'b1, 1'b1, 1'b0, 1'b1, {{4{7'b1111111}}, 7'b0011001, 7'b0100100}};
    vecs[3]  = '{24'd0, 1'b0, 1'b1, 1'b0, 1'b1, {{5{7'b1111111}}, 7'b1000000}};
    vecs[4]  = '{24'd1000000, 1'b1, 1'b0, 1'b1, 1'b1, {6{7'b0111111}}};
    vecs[5]  = '{24'd999999, 1'b1, 1'b0, 1'b0, 1'b1, {6{7'b0010000}}};
    vecs[6]  = '{24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, '0};
    vecs[7]  = '{24'h000100, 1'b0, 1'b1, 1'b0, 1'b0, '0};
    vecs[8]  = '{24'd16777215, 1'b1, 1'b1, 1'b1, 1'b0, '0};
    vecs[9]  = '{24'd100, 1'b1, 1'b1, 1'b0, 1'b0, '0};
    vecs[10] = '{24'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[11] = '{24'h0B0C0D, 1'b0, 1'b1, 1'b0, 1'b0, '0};

    RESET = 1'b1; LOAD = 1'b0; DATA = '0; MODE = 1'b0; BLANK_LZ = 1'b0; BLINK_EN = 1'b0;
    repeat (2) step();
    check("reset_hex", 64'(HEX), 64'(HW'('1)));
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_ovf", 64'(OVF), 64'd0);
    RESET = 1'b0;
    step();
    e = model(24'd0, 1'b0, 1'b0);
    check("post_reset_display", 64'(HEX), 64'(e.hex));

    // Table-driven loads
    for (int i = 0; i < 12; i++) begin
      run_load(vecs[i].data, vecs[i].mode, vecs[i].blz, vecs[i].exp_ovf, $sformatf("vec%0d", i));
      if (vecs[i].has_lit) check($sformatf("vec%0d_literal", i), 64'(HEX), 64'(vecs[i].lit));
    end

    // LOAD during conversion, LOAD on the commit edge, LOAD on the first idle cycle
    sb.push_back(model(24'd555, 1'b1, 1'b0));
    DATA = 24'd555; MODE = 1'b1; BLANK_LZ = 1'b0; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    repeat (4) step();
    DATA = 24'd7; MODE = 1'b0; BLANK_LZ = 1'b1; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    repeat (WIDTH-5) step();
    check("busy_before_commit", 64'(BUSY), 64'd1);
    DATA = 24'h000777; MODE = 1'b0; BLANK_LZ = 1'b0; LOAD = 1'b1;
    step();
    check("busy_after_commit", 64'(BUSY), 64'd0);
    DATA = 24'h000123;
    step();
    LOAD = 1'b0;
    pop_check("busy_load_555");
    sb.push_back(model(24'h000123, 1'b0, 1'b0));
    step();
    pop_check("first_idle_load");

    // Reset in the middle of a conversion, with an overflow display showing
    run_load(24'd1000000, 1'b1, 1'b0, 1'b1, "pre_reset_ovf");
    DATA = 24'd654321; MODE = 1'b1; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    repeat (9) step();
    check("busy_before_reset", 64'(BUSY), 64'd1);
    RESET = 1'b1;
    #1;
    check("midreset_hex", 64'(HEX), 64'(HW'('1)));
    check("midreset_busy", 64'(BUSY), 64'd0);
    check("midreset_ovf", 64'(OVF), 64'd0);
    step();
    RESET = 1'b0;
    repeat (WIDTH+5) step();
    e = model(24'd0, 1'b0, 1'b0);
    check("no_partial_commit_hex", 64'(HEX), 64'(e.hex));
    check("no_partial_commit_ovf", 64'(OVF), 64'd0);
    check("no_partial_commit_busy", 64'(BUSY), 64'd0);

    // Blink with a 4-cycle half period
    run_load(24'h000001, 1'b0, 1'b0, 1'b0, "blink_value");
    e    = model(24'h000001, 1'b0, 1'b0);
    disp = e.hex;
    BLINK_EN = 1'b1;
    step();
    for (int i = 0; i < 24; i++) begin
      s[i] = (HEX === disp) ? 1 : ((HEX === HW'('1)) ? 0 : 2);
      step();
    end
    bad = 0;
    for (int i = 0; i < 24; i++) if (s[i] == 2) bad++;
    check("blink_levels", 64'(bad), 64'd0);
    t0 = 0;
    for (int i = 23; i >= 1; i--) if (s[i] != s[i-1]) t0 = i;
    check("blink_first_toggle_in_range", 64'((t0 >= 1) && (t0 <= 4)), 64'd1);
    bad = 0;
    for (int i = t0; i < 24; i++) begin
      if (s[i] != ((((i - t0) / 4) % 2 == 0) ? s[t0] : (1 - s[t0]))) bad++;
    end
    check("blink_period", 64'(bad), 64'd0);
    BLINK_EN = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (HEX !== disp) bad++;
      step();
    end
    check("blink_off_constant", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit seven-segment display controller for the DE1-SoC HEX bank. It captures a binary value on a load strobe and drives DIGITS active-low segment outputs. In hexadecimal mode the value is shown directly. In decimal mode it is first converted to BCD by a sequential shift-add-3 (double-dabble) engine. Optional leading-zero blanking, an overflow indication and a blink mode are provided. It replaces the per-digit hand-written combinational decoders and sits between the switch/datapath logic and the HEX pins.

## Interface
- DIGITS, 6, number of display digits (1..8)
- WIDTH, 24, binary input width; must equal 4*DIGITS
- BLINK_DIV, 25_000_000, CLOCK_50 cycles per blink half-period (≥2)
- CLOCK_50  in  1  system clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- LOAD  in  1  single-cycle strobe; captures DATA/MODE/BLANK_LZ when BUSY=0
- DATA  in  WIDTH  unsigned binary value to display
- MODE  in  1  0 = hexadecimal, 1 = decimal
- BLANK_LZ  in  1  1 = blank leading zero digits
- BLINK_EN  in  1  1 = blank all digits during the off blink phase; sampled live
- BUSY  out  1  decimal conversion in progress
- OVF  out  1  displayed decimal value exceeds 10^DIGITS−1
- HEX  out  7*DIGITS  segments; digit k on HEX[7k+6:7k], bit0=a … bit6=g, active-low

## Operation
- Segment encoding is active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - Blank = 1111111; dash = 0111111.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - LOAD=1 with MODE=0: latch the DATA nibbles into the digit register and set OVF=0. Remain in IDLE.
  - LOAD=1 with MODE=1: clear the BCD register, load DATA into the shift register, clear the shift count and go to SHIFT. BUSY=1.
- SHIFT:
  - Each cycle, add 3 to every BCD digit ≥5, then shift {BCD, shift} left by 1.
  - Any bit shifted out of the top BCD digit sets the internal overflow flag.
  - After WIDTH shifts go to COMMIT.
- COMMIT: copy BCD into the digit register, load OVF from the internal flag, then go to IDLE. BUSY=0.
- LOAD while BUSY=1 is ignored. DATA, MODE and BLANK_LZ are not re-sampled.
- The digit register, OVF and BLANK_LZ used for display change only at a LOAD in hex mode or at COMMIT. The previous display holds during conversion.
- Display rendering applies the first matching rule:
  - OVF=1: all digits show dash.
  - Otherwise, with the latched BLANK_LZ=1, digits above the most significant nonzero digit are blank. Digit 0 is always shown.
  - Otherwise, each digit shows its decoded segments.
- Blink:
  - A free-running counter counts 0..BLINK_DIV−1 and toggles the phase on wrap.
  - Phase=off with BLINK_EN=1 forces all digits blank; this overrides the rule above.
  - The counter runs independently of LOAD and BUSY.
- HEX is a registered output.

## Timing
- Reset values: HEX all 1s (blank), BUSY=0, OVF=0, state IDLE, digit register 0, blink counter 0, phase=on, latched BLANK_LZ=0.
- Hex mode: LOAD is sampled at edge e. The digit register updates at e, and HEX reflects the new value after edge e+1.
- Decimal mode: LOAD is sampled at edge e.
  - BUSY=1 after e.
  - SHIFT occupies edges e+1..e+WIDTH.
  - COMMIT occurs at edge e+WIDTH+1; BUSY=0 and OVF are valid after it.
  - HEX updates after edge e+WIDTH+2.
- LOAD coincident with COMMIT is ignored. A new LOAD is accepted from the first cycle BUSY=0.
- Changes to BLINK_EN take effect on HEX one edge later.
- RESET asserted mid-conversion aborts immediately: BUSY=0, display blank. No partial commit occurs.

## Test plan
- Hex load (DIGITS=6): LOAD with DATA=0x00A12F, MODE=0, BLANK_LZ=0. Required: next cycle, digits 5..0 show 0,0,A,1,2,F; OVF=0; BUSY never asserts.
- Decimal conversion: DATA=123456, MODE=1. Required: BUSY high exactly 25 cycles (WIDTH+1); HEX then shows 1,2,3,4,5,6; OVF=0; the previous display holds until commit.
- Leading-zero blanking: DATA=42, MODE=1, BLANK_LZ=1. Required: digits 5..2 = 1111111, digit1 = 4, digit0 = 2. Then DATA=0 in hex mode. Required: only digit0 shows 0.
- Overflow: DATA=1_000_000, MODE=1. Required: OVF=1 and all digits = 0111111 after commit. Then DATA=999_999. Required: OVF=0 and display 9,9,9,9,9,9.
- LOAD during BUSY / reset: issue a second LOAD with DATA=7 at cycle 5 of a conversion of 555. Required: result 555. Assert RESET at cycle 10 of a subsequent conversion. Required: HEX blank, BUSY=0, OVF=0 immediately.
- Blink (BLINK_DIV=4): BLINK_EN=1 with 0x000001 displayed. Required: HEX alternates displayed/blank every 4 cycles. With BLINK_EN=0 the display is constant.
